// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding,
// opcode/funct constants and ALU select codes.
// Optional feature macro: MC_CTRL_IMM_EN (adds EXEC_I / I_WB for I-type ALU ops).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
`ifdef MC_CTRL_IMM_EN
        S_JUMP    = 4'd9,
        S_EXEC_I  = 4'd10,
        S_I_WB    = 4'd11
`else
        S_JUMP    = 4'd9
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Opcodes DECODE knows how to dispatch; anything else is flagged illegal.
    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: is_legal_op = 1'b1;
`ifdef MC_CTRL_IMM_EN
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   is_legal_op = 1'b1;
`endif
            default:                             is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_sel_decode.sv
// ALU operation select: decodes state/opcode/funct into ALUSel and flags
// an unsupported funct while in EXEC_R.
// Optional feature macro: MC_CTRL_IMM_EN (opcode-driven select in EXEC_I).
module mc_alu_sel_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alusel,
    output logic        funct_illegal
);

`ifndef MC_CTRL_IMM_EN
    // opcode only steers the ALU in EXEC_I, which this build omits
    logic unused_opcode;
    assign unused_opcode = ^opcode;
`endif

    // ALU select by state; ADD everywhere not explicitly overridden
    always_comb begin
        alusel        = ALU_ADD;
        funct_illegal = 1'b0;
        case (state)
            S_EXEC_R: begin
                case (funct)
                    FN_ADD:  alusel = ALU_ADD;
                    FN_SUB:  alusel = ALU_SUB;
                    FN_AND:  alusel = ALU_AND;
                    FN_OR:   alusel = ALU_OR;
                    FN_SLT:  alusel = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            S_BRANCH: alusel = ALU_SUB;
`ifdef MC_CTRL_IMM_EN
            S_EXEC_I: begin
                case (opcode)
                    OP_ANDI: alusel = ALU_AND;
                    OP_ORI:  alusel = ALU_OR;
                    OP_SLTI: alusel = ALU_SLT;
                    default: alusel = ALU_ADD;
                endcase
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM. Moore outputs from state; only the
// FETCH PC/IR enables and the stall/advance decisions look at mem_ready.
// Optional feature macro: MC_CTRL_IMM_EN (addi/andi/ori/slti via EXEC_I, I_WB).
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        PCWE,
    output logic        IRWE,
    output logic        RFWE,
    output logic        DMWE,
    output logic        IorD,
    output logic        MtoRFSel,
    output logic        RFDSel,
    output logic        ALUSrcA,
    output logic        Branch,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic [3:0]  ALUSel,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t state_q, state_d;
    logic   funct_illegal;
    logic   op_illegal;

    assign state      = state_q;
    assign op_illegal = ~is_legal_op(opcode);

    mc_alu_sel_decode u_alu_sel (
        .state         (state_q),
        .opcode        (opcode),
        .funct         (funct),
        .alusel        (ALUSel),
        .funct_illegal (funct_illegal)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state: memory states hold until mem_ready, decode dispatches on opcode
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_IMM_EN
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:  state_d = funct_illegal ? S_FETCH : S_ALU_WB;
`ifdef MC_CTRL_IMM_EN
            S_EXEC_I:  state_d = S_I_WB;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    // Output decode; reset forces every write enable and illegal low
    always_comb begin
        PCWE     = 1'b0;
        IRWE     = 1'b0;
        RFWE     = 1'b0;
        DMWE     = 1'b0;
        IorD     = 1'b0;
        MtoRFSel = 1'b0;
        RFDSel   = 1'b0;
        ALUSrcA  = 1'b0;
        Branch   = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                PCWE    = mem_ready;
                IRWE    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                illegal = op_illegal;
            end
            S_MEM_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD:  IorD = 1'b1;
            S_MEM_WB: begin
                MtoRFSel = 1'b1;
                RFWE     = 1'b1;
            end
            S_MEM_WR: begin
                IorD = 1'b1;
                DMWE = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                illegal = funct_illegal;
            end
            S_ALU_WB: begin
                RFDSel = 1'b1;
                RFWE   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                Branch  = 1'b1;
                PCSrc   = 2'b01;
            end
            S_JUMP: begin
                PCSrc = 2'b10;
                PCWE  = 1'b1;
            end
`ifdef MC_CTRL_IMM_EN
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_I_WB:    RFWE = 1'b1;
`endif
            default: ;
        endcase
        if (rst) begin
            PCWE    = 1'b0;
            IRWE    = 1'b0;
            RFWE    = 1'b0;
            DMWE    = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule
